// File: rtl/enc8to3_queue.sv
// Sequential 8-to-3 encoder: captures multi-hot requests into a pending
// register and serves them one code per valid/ready transfer.
module enc8to3_queue #(
    parameter bit RR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       en,
    input  logic       ready,
    output logic [2:0] out,
    output logic       valid,
    output logic [7:0] pend,
    output logic       ovf
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] out_q;
    logic [2:0] out_d;
    logic [2:0] ptr_q;
    logic [2:0] ptr_d;
    logic [7:0] pend_q;
    logic [7:0] pend_d;
    logic       ovf_q;
    logic       ovf_d;

    logic       xfer;
    logic [7:0] clr;
    logic [7:0] cap;
    logic [7:0] rem;
    logic [2:0] base;
    logic [2:0] next_base;

    // First set bit of v at or above p, wrapping 7 -> 0.
    function automatic logic [2:0] sel(
        input logic [7:0] v,
        input logic [2:0] p
    );
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  idx;
        dbl = {v, v} >> p;
        rot = dbl[7:0];
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                idx = i[2:0];
            end
        end
        return p + idx;
    endfunction

    assign valid = (state_q == OFFER);
    assign out   = out_q;
    assign pend  = pend_q;
    assign ovf   = ovf_q;

    always_comb begin
        xfer      = valid && ready;
        clr       = xfer ? (8'h01 << out_q) : 8'h00;
        cap       = en ? in : 8'h00;
        rem       = pend_q & ~clr;
        pend_d    = rem | cap;
        ovf_d     = |(cap & rem);
        base      = RR ? ptr_q : 3'd0;
        next_base = RR ? (out_q + 3'd1) : 3'd0;
    end

    // Only the registered pend is searched on a transfer; same-cycle
    // captures become visible one cycle later.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    out_d   = sel(pend_q, base);
                    state_d = OFFER;
                end else begin
                    out_d = 3'd0;
                end
            end
            OFFER: begin
                if (xfer) begin
                    ptr_d = out_q + 3'd1;
                    if (|rem) begin
                        out_d = sel(rem, next_base);
                    end else begin
                        out_d   = 3'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= 3'd0;
            ptr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 8'h00;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_enc8to3_queue.sv
// Bench for enc8to3_queue: directed vector table on both arbitration
// modes, then random traffic against a reference model.
module tb_enc8to3_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       en = 1'b0;
    logic       ready = 1'b0;

    logic [2:0] out0, out1;
    logic       valid0, valid1;
    logic [7:0] pend0, pend1;
    logic       ovf0, ovf1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    enc8to3_queue #(.RR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in(din), .en(en), .ready(ready),
        .out(out0), .valid(valid0), .pend(pend0), .ovf(ovf0)
    );

    enc8to3_queue #(.RR(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in(din), .en(en), .ready(ready),
        .out(out1), .valid(valid1), .pend(pend1), .ovf(ovf1)
    );

    // reference model, index = arbitration mode
    logic [7:0] mp[2];
    bit         mv[2];
    int         mo[2];
    int         mptr[2];
    bit         movf[2];

    typedef struct {
        logic        r;
        logic        e;
        logic [7:0]  d;
        logic        rd;
        logic [12:0] e0;
        logic [12:0] e1;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [12:0] mk(bit o, bit v, int c, logic [7:0] p);
        return {o, v, 3'(c), p};
    endfunction

    function automatic int first_from(logic [7:0] v, int p);
        for (int k = 0; k < 8; k++) begin
            if (v[(p + k) % 8]) return (p + k) % 8;
        end
        return 0;
    endfunction

    task automatic model_edge(input logic r, e, input logic [7:0] d,
                              input logic rd);
        for (int m = 0; m < 2; m++) begin
            logic [7:0] clrm, keep, np;
            if (r) begin
                mp[m] = 8'h00; mv[m] = 0; mo[m] = 0;
                mptr[m] = 0; movf[m] = 0;
            end else begin
                clrm = (mv[m] && rd) ? (8'h01 << mo[m]) : 8'h00;
                keep = mp[m] & ~clrm;
                movf[m] = e && ((d & keep) != 0);
                np = keep | (e ? d : 8'h00);
                if (!mv[m]) begin
                    if (mp[m] != 0) begin
                        mo[m] = first_from(mp[m], m ? mptr[m] : 0);
                        mv[m] = 1;
                    end else begin
                        mo[m] = 0;
                    end
                end else if (rd) begin
                    mptr[m] = (mo[m] + 1) % 8;
                    if (keep != 0) begin
                        mo[m] = first_from(keep, m ? (mo[m] + 1) % 8 : 0);
                    end else begin
                        mo[m] = 0;
                        mv[m] = 0;
                    end
                end
                mp[m] = np;
            end
        end
    endtask

    task automatic check(input string name, input logic [12:0] got,
                         input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got{ovf,valid,out,pend}=%h required=%h",
                     name, got, exp);
        end
    endtask

    task automatic step(input logic r, e, input logic [7:0] d,
                        input logic rd);
        rst = r; en = e; din = d; ready = rd;
        @(posedge clk);
        model_edge(r, e, d, rd);
        #1;
        check("model_rr0", {ovf0, valid0, out0, pend0},
              mk(movf[0], mv[0], mo[0], mp[0]));
        check("model_rr1", {ovf1, valid1, out1, pend1},
              mk(movf[1], mv[1], mo[1], mp[1]));
    endtask

    task automatic v2(input logic r, e, input logic [7:0] d, input logic rd,
                      input logic [12:0] x0, input logic [12:0] x1);
        vec_t t;
        t.r = r; t.e = e; t.d = d; t.rd = rd; t.e0 = x0; t.e1 = x1;
        vecs.push_back(t);
    endtask

    task automatic v(input logic r, e, input logic [7:0] d, input logic rd,
                     input logic [12:0] x);
        v2(r, e, d, rd, x, x);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            mp[m] = 0; mv[m] = 0; mo[m] = 0; mptr[m] = 0; movf[m] = 0;
        end
        // reset with requests asserted, then first offer
        v(1, 1, 8'hFF, 1, mk(0, 0, 0, 8'h00));
        v(1, 1, 8'hFF, 1, mk(0, 0, 0, 8'h00));
        v(0, 1, 8'hFF, 0, mk(0, 0, 0, 8'hFF));
        v(0, 0, 8'h00, 0, mk(0, 1, 0, 8'hFF));
        // fixed priority drain 2,5,7
        v(1, 0, 8'h00, 0, mk(0, 0, 0, 8'h00));
        v(0, 1, 8'hA4, 1, mk(0, 0, 0, 8'hA4));
        v(0, 0, 8'h00, 1, mk(0, 1, 2, 8'hA4));
        v(0, 0, 8'h00, 1, mk(0, 1, 5, 8'hA0));
        v(0, 0, 8'h00, 1, mk(0, 1, 7, 8'h80));
        v(0, 0, 8'h00, 1, mk(0, 0, 0, 8'h00));
        // grant 5 then inject 0x23 -> 0,1,5
        v(1, 0, 8'h00, 0, mk(0, 0, 0, 8'h00));
        v(0, 1, 8'h20, 1, mk(0, 0, 0, 8'h20));
        v(0, 0, 8'h00, 1, mk(0, 1, 5, 8'h20));
        v(0, 1, 8'h23, 1, mk(0, 0, 0, 8'h23));
        v(0, 0, 8'h00, 1, mk(0, 1, 0, 8'h23));
        v(0, 0, 8'h00, 1, mk(0, 1, 1, 8'h22));
        v(0, 0, 8'h00, 1, mk(0, 1, 5, 8'h20));
        v(0, 0, 8'h00, 1, mk(0, 0, 0, 8'h00));
        // modes diverge: remaining bits straddle the granted index
        v(1, 0, 8'h00, 0, mk(0, 0, 0, 8'h00));
        v(0, 1, 8'h04, 0, mk(0, 0, 0, 8'h04));
        v(0, 0, 8'h00, 0, mk(0, 1, 2, 8'h04));
        v(0, 1, 8'h11, 0, mk(0, 1, 2, 8'h15));
        v2(0, 0, 8'h00, 1, mk(0, 1, 0, 8'h11), mk(0, 1, 4, 8'h11));
        v2(0, 0, 8'h00, 1, mk(0, 1, 4, 8'h10), mk(0, 1, 0, 8'h01));
        v(0, 0, 8'h00, 1, mk(0, 0, 0, 8'h00));
        // stall holds offer while a higher-priority request lands
        v(1, 0, 8'h00, 0, mk(0, 0, 0, 8'h00));
        v(0, 1, 8'h08, 0, mk(0, 0, 0, 8'h08));
        v(0, 0, 8'h00, 0, mk(0, 1, 3, 8'h08));
        v(0, 1, 8'h01, 0, mk(0, 1, 3, 8'h09));
        v(0, 0, 8'h00, 0, mk(0, 1, 3, 8'h09));
        v(0, 0, 8'h00, 0, mk(0, 1, 3, 8'h09));
        v(0, 0, 8'h00, 0, mk(0, 1, 3, 8'h09));
        v(0, 0, 8'h00, 1, mk(0, 1, 0, 8'h01));
        v(0, 0, 8'h00, 1, mk(0, 0, 0, 8'h00));
        // overflow pulse, then same-cycle set beats clear
        v(1, 0, 8'h00, 0, mk(0, 0, 0, 8'h00));
        v(0, 1, 8'h08, 0, mk(0, 0, 0, 8'h08));
        v(0, 0, 8'h00, 0, mk(0, 1, 3, 8'h08));
        v(0, 1, 8'h08, 0, mk(1, 1, 3, 8'h08));
        v(0, 0, 8'h00, 0, mk(0, 1, 3, 8'h08));
        v(0, 1, 8'h08, 1, mk(0, 0, 0, 8'h08));
        v(0, 0, 8'h00, 0, mk(0, 1, 3, 8'h08));
        // reset mid-drain clears pend, offer and rr pointer
        v(1, 0, 8'h00, 0, mk(0, 0, 0, 8'h00));
        v(0, 1, 8'hF0, 0, mk(0, 0, 0, 8'hF0));
        v(0, 0, 8'h00, 0, mk(0, 1, 4, 8'hF0));
        v(0, 0, 8'h00, 1, mk(0, 1, 5, 8'hE0));
        v(1, 0, 8'h00, 1, mk(0, 0, 0, 8'h00));
        v(0, 0, 8'h00, 1, mk(0, 0, 0, 8'h00));
        v(0, 0, 8'h00, 1, mk(0, 0, 0, 8'h00));
        v(0, 1, 8'h81, 0, mk(0, 0, 0, 8'h81));
        v(0, 0, 8'h00, 0, mk(0, 1, 0, 8'h81));
        v(0, 0, 8'h00, 1, mk(0, 1, 7, 8'h80));
        v(0, 0, 8'h00, 1, mk(0, 0, 0, 8'h00));

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].e, vecs[i].d, vecs[i].rd);
            check($sformatf("vec%0d_rr0", i),
                  {ovf0, valid0, out0, pend0}, vecs[i].e0);
            check($sformatf("vec%0d_rr1", i),
                  {ovf1, valid1, out1, pend1}, vecs[i].e1);
        end

        for (int n = 0; n < 3000; n++) begin
            logic       r, e, rd;
            logic [7:0] d;
            r  = ($urandom_range(0, 63) == 0);
            e  = ($urandom_range(0, 2) == 0);
            d  = 8'($urandom & $urandom);
            rd = ($urandom_range(0, 3) != 0);
            step(r, e, d, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
